// File: rtl/cast_vc_allocator_pkg.sv
// cast_alloc_pkg: shared types and helpers for the output-VC allocator and
// its round-robin arbiter.
//   vc_state_t     : per-output-VC occupancy (free / allocated)
//   FLIT_*         : two-bit flit type encodings carried on vc_flit_type
//   vcw()          : index width for a count of items (minimum 1 bit)
//   lsb_idx()      : index of the lowest set bit of a 32-bit vector (0 if none)
package cast_alloc_pkg;

   typedef enum logic {
      VC_FREE  = 1'b0,
      VC_ALLOC = 1'b1
   } vc_state_t;

   localparam logic [1:0] FLIT_HEAD     = 2'b00;
   localparam logic [1:0] FLIT_BODY     = 2'b01;
   localparam logic [1:0] FLIT_TAIL     = 2'b10;
   localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

   function automatic int vcw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned lsb_idx(input logic [31:0] v);
      int unsigned idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) idx = unsigned'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/cast_vc_allocator_if.sv
// cast_vc_allocator_if: request/grant and per-VC flit signalling between the
// route-compute stage, the allocator and the output-VC stages.
//   req          : head flit of input VC i targets this port
//   grant        : one-cycle one-hot grant pulse
//   grant_vc     : packed output-VC id per requester (VCW bits each)
//   vc_fire      : flit transferred on output VC v
//   vc_flit_type : two-bit flit type per output VC
//   vc_available : output VC v is free
//   timeout_err  : pulse on forced release of a stuck allocation
// master = requester/output-stage side, slave = allocator.
interface cast_vc_allocator_if #(
   parameter int NUM_IN = 5,
   parameter int NUM_VC = 2
) ();
   localparam int VCW = cast_alloc_pkg::vcw(NUM_VC);

   logic [NUM_IN-1:0]     req;
   logic [NUM_IN-1:0]     grant;
   logic [NUM_IN*VCW-1:0] grant_vc;
   logic [NUM_VC-1:0]     vc_fire;
   logic [NUM_VC*2-1:0]   vc_flit_type;
   logic [NUM_VC-1:0]     vc_available;
   logic                  timeout_err;

   modport master (
      output req, vc_fire, vc_flit_type,
      input  grant, grant_vc, vc_available, timeout_err
   );

   modport slave (
      input  req, vc_fire, vc_flit_type,
      output grant, grant_vc, vc_available, timeout_err
   );
endinterface

// File: rtl/cast_vc_allocator_rr_arbiter.sv
// cast_rr_arbiter: round-robin arbiter, combinational one-hot grant with a
// registered priority pointer.
//   clk, rst : clock, synchronous active-high reset (pointer to 0)
//   req_i    : request vector
//   en_i     : grant accepted; pointer moves to winner+1 (mod N)
//   gnt_o    : one-hot grant, first requester at or above the pointer,
//              wrapping to the lowest requester
module cast_rr_arbiter
   import cast_alloc_pkg::*;
#(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   output logic [N-1:0] gnt_o
);
   localparam int PW = vcw(N);

   logic [PW-1:0] ptr_q;
   logic [N-1:0]  req_hi;
   int unsigned   win;

   always_comb begin
      req_hi = '0;
      for (int i = 0; i < N; i++) begin
         req_hi[i] = req_i[i] && (PW'(i) >= ptr_q);
      end
      win = (|req_hi) ? lsb_idx(32'(req_hi)) : lsb_idx(32'(req_i));
      gnt_o = '0;
      for (int i = 0; i < N; i++) begin
         gnt_o[i] = (|req_i) && (win == unsigned'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (en_i) begin
         ptr_q <= (win == unsigned'(N - 1)) ? '0 : PW'(win + 1);
      end
   end

endmodule

// File: rtl/cast_vc_allocator.sv
// cast_vc_allocator: output-VC allocator for one router output port. Shares
// NUM_VC output VCs among NUM_IN requesting input VCs, round-robin.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cast_vc_allocator_if.slave (req in; grant, grant_vc,
//              vc_available, timeout_err out; vc_fire, vc_flit_type in)
// Optional: define CAST_VC_TIMEOUT_EN to reclaim an allocated VC that sees
// no flit for TIMEOUT cycles; otherwise timeout_err is tied 0.
//
// Per-VC state:
//   state    | meaning
//   VC_FREE  | VC unowned, may be granted
//   VC_ALLOC | VC owned by owner_q; freed on tail fire (or idle timeout)
module cast_vc_allocator
   import cast_alloc_pkg::*;
#(
   parameter int NUM_IN  = 5,
   parameter int NUM_VC  = 2,
   parameter int TIMEOUT = 1024
) (
   input logic                clk,
   input logic                rst,
   cast_vc_allocator_if.slave bus
);
   localparam int VCW = vcw(NUM_VC);
   localparam int IW  = vcw(NUM_IN);

   vc_state_t                  state_q [NUM_VC];
   logic [IW-1:0]              owner_q [NUM_VC];
   logic [NUM_IN-1:0]          req_q;
   logic [NUM_IN-1:0]          grant_q;
   logic [NUM_IN-1:0][VCW-1:0] gvc_q;

   logic [NUM_VC-1:0] free, rel, tmo;
   logic [NUM_IN-1:0] owned, rel_owner, elig, arb_gnt;
   logic              win_valid;
   logic [VCW-1:0]    vc_sel;
   logic [IW-1:0]     win_idx;

   always_comb begin
      free      = '0;
      rel       = '0;
      owned     = '0;
      rel_owner = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         free[v] = (state_q[v] == VC_FREE);
         rel[v]  = !free[v] && bus.vc_fire[v] &&
                   (bus.vc_flit_type[2*v +: 2] == FLIT_TAIL);
         for (int i = 0; i < NUM_IN; i++) begin
            if (!free[v] && (owner_q[v] == IW'(i))) begin
               owned[i] = 1'b1;
               if (rel[v] || tmo[v]) rel_owner[i] = 1'b1;
            end
         end
      end
   end

   // Requesters that already own a VC are masked; nothing competes unless a
   // VC is free, so the pointer only moves on a real allocation.
   assign elig      = (|free) ? (req_q & ~owned) : '0;
   assign win_valid = |arb_gnt;
   assign vc_sel    = VCW'(lsb_idx(32'(free)));
   assign win_idx   = IW'(lsb_idx(32'(arb_gnt)));

   cast_rr_arbiter #(.N(NUM_IN)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (elig),
      .en_i  (win_valid),
      .gnt_o (arb_gnt)
   );

   // Releases act on ALLOC VCs and allocation on the lowest FREE VC, so the
   // two never target the same VC in one cycle; a released VC is granted no
   // earlier than the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q   <= '0;
         grant_q <= '0;
         gvc_q   <= '0;
         for (int v = 0; v < NUM_VC; v++) begin
            state_q[v] <= VC_FREE;
            owner_q[v] <= '0;
         end
      end else begin
         req_q   <= bus.req;
         grant_q <= arb_gnt;
         for (int v = 0; v < NUM_VC; v++) begin
            if (rel[v] || tmo[v]) begin
               state_q[v] <= VC_FREE;
            end else if (win_valid && (vc_sel == VCW'(v))) begin
               state_q[v] <= VC_ALLOC;
               owner_q[v] <= win_idx;
            end
         end
         for (int i = 0; i < NUM_IN; i++) begin
            if (arb_gnt[i])        gvc_q[i] <= vc_sel;
            else if (rel_owner[i]) gvc_q[i] <= '0;
         end
      end
   end

`ifdef CAST_VC_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] idle_q [NUM_VC];
   logic          terr_q;

   always_comb begin
      tmo = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         tmo[v] = (state_q[v] == VC_ALLOC) && !bus.vc_fire[v] &&
                  (idle_q[v] == CW'(TIMEOUT));
      end
   end

   // Counter is held at 0 while FREE, so a fresh grant starts from 0; it
   // saturates at TIMEOUT, where the forced release takes over.
   always_ff @(posedge clk) begin
      if (rst) begin
         terr_q <= 1'b0;
         for (int v = 0; v < NUM_VC; v++) idle_q[v] <= '0;
      end else begin
         terr_q <= |tmo;
         for (int v = 0; v < NUM_VC; v++) begin
            if (bus.vc_fire[v] || (state_q[v] == VC_FREE)) idle_q[v] <= '0;
            else if (idle_q[v] != CW'(TIMEOUT))            idle_q[v] <= idle_q[v] + 1'b1;
         end
      end
   end

   assign bus.timeout_err = terr_q;
`else
   logic unused_timeout;
   assign unused_timeout  = ^TIMEOUT;
   assign tmo             = '0;
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.grant        = grant_q;
   assign bus.grant_vc     = gvc_q;
   assign bus.vc_available = free;

endmodule

// File: tb/tb_cast_vc_allocator.sv
// Testbench for cast_vc_allocator: directed scenarios followed by random
// traffic, every cycle compared against a behavioural allocation model.
module tb_cast_vc_allocator;
   import cast_alloc_pkg::*;

   localparam int NUM_IN  = 5;
   localparam int NUM_VC  = 2;
   localparam int TIMEOUT = 8;
   localparam int VCW     = vcw(NUM_VC);
`ifdef CAST_VC_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst_v;
   logic [NUM_IN-1:0]   req_v;
   logic [NUM_VC-1:0]   fire_v;
   logic [NUM_VC*2-1:0] type_v;

   cast_vc_allocator_if #(.NUM_IN(NUM_IN), .NUM_VC(NUM_VC)) bus ();
   assign bus.req          = req_v;
   assign bus.vc_fire      = fire_v;
   assign bus.vc_flit_type = type_v;

   cast_vc_allocator #(.NUM_IN(NUM_IN), .NUM_VC(NUM_VC), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst_v),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: which requester holds each VC (-1 = nobody), the
   // request seen one cycle earlier, and the round-robin starting point.
   int                m_owner [NUM_VC];
   int                m_idle  [NUM_VC];
   int                m_gvc   [NUM_IN];
   logic [NUM_IN-1:0] m_req_d;
   logic [NUM_IN-1:0] m_grant;
   int                m_ptr;
   logic              m_terr;
   int                m_last_vc;

   function automatic logic [NUM_VC-1:0] m_avail();
      logic [NUM_VC-1:0] a;
      for (int v = 0; v < NUM_VC; v++) a[v] = (m_owner[v] < 0);
      return a;
   endfunction

   function automatic bit m_owns(input int i);
      for (int v = 0; v < NUM_VC; v++) if (m_owner[v] == i) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step();
      int win, vc;
      if (rst_v) begin
         for (int v = 0; v < NUM_VC; v++) begin m_owner[v] = -1; m_idle[v] = 0; end
         for (int i = 0; i < NUM_IN; i++) m_gvc[i] = 0;
         m_req_d = '0; m_grant = '0; m_ptr = 0; m_terr = 1'b0;
         return;
      end
      win = -1;
      vc  = -1;
      for (int v = NUM_VC - 1; v >= 0; v--) if (m_owner[v] < 0) vc = v;
      if (vc >= 0) begin
         for (int k = 0; k < NUM_IN; k++) begin
            int i;
            i = (m_ptr + k) % NUM_IN;
            if (win < 0 && m_req_d[i] && !m_owns(i)) win = i;
         end
      end
      m_terr = 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
         if (m_owner[v] >= 0) begin
            if (fire_v[v]) begin
               m_idle[v] = 0;
               if (type_v[2*v +: 2] == FLIT_TAIL) begin
                  m_gvc[m_owner[v]] = 0;
                  m_owner[v] = -1;
               end
            end else if (TMO_EN && m_idle[v] == TIMEOUT) begin
               m_gvc[m_owner[v]] = 0;
               m_owner[v] = -1;
               m_terr = 1'b1;
            end else begin
               m_idle[v]++;
            end
         end
      end
      m_grant = '0;
      if (win >= 0) begin
         m_owner[vc] = win;
         m_idle[vc]  = 0;
         m_gvc[win]  = vc;
         m_grant[win] = 1'b1;
         m_ptr = (win + 1) % NUM_IN;
         m_last_vc = vc;
      end
      m_req_d = req_v;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("grant", 32'(bus.grant), 32'(m_grant));
      chk("vc_available", 32'(bus.vc_available), 32'(m_avail()));
      for (int i = 0; i < NUM_IN; i++)
         chk($sformatf("grant_vc[%0d]", i), 32'(bus.grant_vc[i*VCW +: VCW]), 32'(m_gvc[i]));
      chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
   endtask

   function automatic int gvc_of(input int i);
      return int'(bus.grant_vc[i*VCW +: VCW]);
   endfunction

   task automatic do_reset();
      rst_v = 1'b1; req_v = '0; fire_v = '0; type_v = '0;
      cyc();
      rst_v = 1'b0;
   endtask

   int        tl [NUM_VC];
   int        order [$];
   int        exp_ord [6] = '{0, 1, 2, 3, 4, 0};
   int        terr_cnt;

   initial begin
      rst_v = 1'b1; req_v = '0; fire_v = '0; type_v = '0;

      // Reset
      cyc();
      cyc();
      rst_v = 1'b0;
      chk("rst_avail", 32'(bus.vc_available), 32'h3);
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_terr",  32'(bus.timeout_err), 32'h0);

      // Single packet, plus non-tail fire and fire on a free VC
      req_v = 5'b00001;
      cyc();
      chk("single_early", 32'(bus.grant), 32'h0);
      cyc();
      chk("single_grant", 32'(bus.grant), 32'h01);
      chk("single_gvc",   32'(gvc_of(0)), 32'h0);
      chk("single_avail", 32'(bus.vc_available), 32'h2);
      req_v = '0;
      cyc();
      chk("single_pulse", 32'(bus.grant), 32'h0);
      fire_v = 2'b11; type_v = {FLIT_TAIL, FLIT_BODY};
      cyc();
      fire_v = '0;
      chk("body_hold", 32'(bus.vc_available), 32'h2);
      fire_v = 2'b01; type_v = {FLIT_BODY, FLIT_TAIL};
      cyc();
      fire_v = '0;
      chk("tail_avail", 32'(bus.vc_available), 32'h3);
      chk("tail_gvc",   32'(gvc_of(0)), 32'h0);

      // Contention: everyone requests, tails two cycles after each grant
      do_reset();
      req_v = '1;
      for (int v = 0; v < NUM_VC; v++) tl[v] = 0;
      for (int c = 0; c < 30; c++) begin
         cyc();
         for (int i = 0; i < NUM_IN; i++) if (bus.grant[i]) order.push_back(i);
         fire_v = '0;
         for (int v = 0; v < NUM_VC; v++) begin
            if (tl[v] > 0) begin
               tl[v]--;
               if (tl[v] == 0) begin fire_v[v] = 1'b1; type_v[2*v +: 2] = FLIT_TAIL; end
            end
         end
         if (m_grant != '0) tl[m_last_vc] = 1;
      end
      fire_v = '0; req_v = '0;
      for (int k = 0; k < 6; k++)
         chk($sformatf("rr_order[%0d]", k), 32'((k < order.size()) ? order[k] : 99), 32'(exp_ord[k]));

      // Exhaustion, then release of VC1 goes to the next RR requester
      do_reset();
      req_v = 5'b00011;
      cyc(); cyc(); cyc();
      req_v = 5'b00111;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("exh_nogrant", 32'(bus.grant), 32'h0);
      end
      fire_v = 2'b10; type_v = {FLIT_TAIL, FLIT_BODY};
      cyc();
      fire_v = '0;
      chk("exh_tail_grant", 32'(bus.grant), 32'h0);
      chk("exh_tail_avail", 32'(bus.vc_available), 32'h2);
      cyc();
      chk("exh_regrant", 32'(bus.grant), 32'h04);
      chk("exh_gvc2",    32'(gvc_of(2)), 32'h1);
      chk("exh_avail",   32'(bus.vc_available), 32'h0);

      // Mid-packet reset drops everything and resets the pointer
      req_v = '0; rst_v = 1'b1;
      cyc();
      rst_v = 1'b0;
      chk("mrst_avail", 32'(bus.vc_available), 32'h3);
      chk("mrst_gvc2",  32'(gvc_of(2)), 32'h0);
      chk("mrst_grant", 32'(bus.grant), 32'h0);
      req_v = 5'b10010;
      cyc(); cyc();
      chk("mrst_ptr0", 32'(bus.grant), 32'h02);
      req_v = '0;
      cyc();

      // Idle allocation: reclaimed only when the timeout is built in
      do_reset();
      req_v = 5'b00001;
      cyc(); cyc();
      req_v = '0;
      terr_cnt = 0;
      for (int c = 0; c < 14; c++) begin
         cyc();
         if (bus.timeout_err) terr_cnt++;
      end
      chk("tmo_pulses", 32'(terr_cnt), TMO_EN ? 32'h1 : 32'h0);
      chk("tmo_avail",  32'(bus.vc_available), TMO_EN ? 32'h3 : 32'h2);

      // Random traffic
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         rst_v  = ($urandom_range(0, 199) == 0);
         req_v  = NUM_IN'($urandom);
         for (int v = 0; v < NUM_VC; v++) begin
            fire_v[v] = ($urandom_range(0, 3) == 0);
            type_v[2*v +: 2] = 2'($urandom_range(0, 3));
         end
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
